// File: rtl/phase_timer_if.sv
// Request/done bundle between the light-control FSM (master) and phase_timer (slave).
interface phase_timer_if #(
  parameter int CNT_W = 32
);
  logic             reds_on_flag;
  logic             need_white2Tminus_flag;
  logic             need_green2yellow_flag;
  logic             need_red_flag;
  logic             white2Tminus_flag;
  logic             green2yellow_flag;
  logic             red_flag;
  logic             busy;
  logic [CNT_W-1:0] remaining;

  modport master (
    output reds_on_flag, need_white2Tminus_flag, need_green2yellow_flag, need_red_flag,
    input  white2Tminus_flag, green2yellow_flag, red_flag, busy, remaining
  );

  modport slave (
    input  reds_on_flag, need_white2Tminus_flag, need_green2yellow_flag, need_red_flag,
    output white2Tminus_flag, green2yellow_flag, red_flag, busy, remaining
  );
endinterface

// File: rtl/phase_timer.sv
// Phase duration timer answering the light-control FSM's need_* requests with done flags.
// Optional PHASE_TIMER_HOLD_EN: done flag held until the latched request drops.
module phase_timer #(
  parameter int CNT_W        = 32,
  parameter int WHITE_CYCLES = 500,
  parameter int GREEN_CYCLES = 300,
  parameter int RED_CYCLES   = 100
) (
  input  logic          clk,
  input  logic          reset,
  phase_timer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, WAIT_DROP} state_t;
  typedef enum logic [1:0] {PH_WHITE, PH_GREEN, PH_RED} phase_t;

  localparam logic [CNT_W-1:0] WHITE_LOAD = CNT_W'(WHITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LOAD = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RED_LOAD   = CNT_W'(RED_CYCLES - 1);

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             busy_q, busy_d;
  logic             white_q, white_d;
  logic             green_q, green_d;
  logic             red_q, red_d;
  logic             req_latched;
  logic             any_req;

  always_comb begin
    unique case (phase_q)
      PH_RED:   req_latched = bus.need_red_flag;
      PH_GREEN: req_latched = bus.need_green2yellow_flag;
      default:  req_latched = bus.need_white2Tminus_flag;
    endcase
    any_req = bus.need_red_flag | bus.need_green2yellow_flag | bus.need_white2Tminus_flag;

    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = RUN;
          if (bus.need_red_flag) begin
            phase_d = PH_RED;
            count_d = RED_LOAD;
          end else if (bus.need_green2yellow_flag) begin
            phase_d = PH_GREEN;
            count_d = GREEN_LOAD;
          end else begin
            phase_d = PH_WHITE;
            count_d = WHITE_LOAD;
          end
        end
      end
      RUN: begin
        // A withdrawn request aborts silently, even on the final count.
        if (!req_latched) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == '0) begin
          state_d = DONE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      DONE: begin
`ifdef PHASE_TIMER_HOLD_EN
        if (!req_latched) state_d = IDLE;
`else
        state_d = WAIT_DROP;
`endif
      end
      WAIT_DROP: begin
        if (!req_latched) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.reds_on_flag) begin
      state_d = IDLE;
      count_d = '0;
    end

    // Outputs are registered, so derive them from the next state.
    busy_d      = (state_d == RUN);
    remaining_d = busy_d ? count_d + CNT_W'(1) : '0;
    white_d     = (state_d == DONE) && (phase_d == PH_WHITE);
    green_d     = (state_d == DONE) && (phase_d == PH_GREEN);
    red_d       = (state_d == DONE) && (phase_d == PH_RED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= PH_WHITE;
      count_q     <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      white_q     <= 1'b0;
      green_q     <= 1'b0;
      red_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      white_q     <= white_d;
      green_q     <= green_d;
      red_q       <= red_d;
    end
  end

  assign bus.white2Tminus_flag = white_q;
  assign bus.green2yellow_flag = green_q;
  assign bus.red_flag          = red_q;
  assign bus.busy              = busy_q;
  assign bus.remaining         = remaining_q;
endmodule

// File: tb/tb_phase_timer.sv
// Bench for phase_timer: directed scenarios then random requests, checked each cycle
// against an elapsed-time model of the active phase.
module tb_phase_timer;
  localparam int CNT_W = 8;
  localparam int WHITE = 4;
  localparam int GREEN = 3;
  localparam int RED   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  phase_timer_if #(.CNT_W(CNT_W)) bus ();

  phase_timer #(
    .CNT_W(CNT_W), .WHITE_CYCLES(WHITE), .GREEN_CYCLES(GREEN), .RED_CYCLES(RED)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  // Model: active phase (-1 none, 0 white, 1 green, 2 red) and edges elapsed since accept.
  int m_ph  = -1;
  int m_el  = 0;

  function automatic int dur(int p);
    case (p)
      0:       return WHITE;
      1:       return GREEN;
      default: return RED;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle(bit rst, bit reds, bit w, bit g, bit r, bit verbose);
    bit need [3];
    logic [31:0] e_rem;
    bit e_busy;
    reset = rst;
    bus.reds_on_flag = reds;
    bus.need_white2Tminus_flag = w;
    bus.need_green2yellow_flag = g;
    bus.need_red_flag = r;
    need[0] = w; need[1] = g; need[2] = r;
    @(posedge clk);
    cyc++;
    if (rst || reds) begin
      m_ph = -1;
      m_el = 0;
    end else if (m_ph < 0) begin
      m_el = 0;
      if (r) m_ph = 2;
      else if (g) m_ph = 1;
      else if (w) m_ph = 0;
    end else if (m_el == dur(m_ph)) begin
`ifdef PHASE_TIMER_HOLD_EN
      if (!need[m_ph]) m_ph = -1;
`else
      m_el++;
`endif
    end else if (!need[m_ph]) begin
      m_ph = -1;
    end else if (m_el < dur(m_ph)) begin
      m_el++;
    end
    #1;
    e_busy = (m_ph >= 0) && (m_el < dur(m_ph));
    e_rem  = e_busy ? 32'(dur(m_ph) - m_el) : 32'd0;
    check("busy",      32'(bus.busy), 32'(e_busy));
    check("remaining", 32'(bus.remaining), e_rem);
    check("white_done", 32'(bus.white2Tminus_flag), 32'(m_ph == 0 && m_el == WHITE));
    check("green_done", 32'(bus.green2yellow_flag), 32'(m_ph == 1 && m_el == GREEN));
    check("red_done",   32'(bus.red_flag),          32'(m_ph == 2 && m_el == RED));
    if (verbose)
      $display("cyc %0d rst=%0b reds=%0b need(w,g,r)=%0b%0b%0b -> busy=%0b rem=%0d done(w,g,r)=%0b%0b%0b",
               cyc, rst, reds, w, g, r, bus.busy, bus.remaining,
               bus.white2Tminus_flag, bus.green2yellow_flag, bus.red_flag);
  endtask

  initial begin
    bit rw, rg, rr;
    // Reset
    repeat (2) cycle(1, 0, 0, 0, 0, 1);
    // Green held through completion, then dropped
    repeat (6) cycle(0, 0, 0, 1, 0, 1);
    repeat (2) cycle(0, 0, 0, 0, 0, 1);
    // Red and white together: red wins, white follows once red drops
    repeat (4) cycle(0, 0, 1, 0, 1, 1);
    repeat (8) cycle(0, 0, 1, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0, 0, 1);
    // White withdrawn after two RUN cycles
    repeat (3) cycle(0, 0, 1, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0, 0, 1);
    // reds_on pulse mid-RUN, request ignored while it is high
    repeat (2) cycle(0, 0, 1, 0, 0, 1);
    repeat (2) cycle(0, 1, 1, 0, 0, 1);
    repeat (6) cycle(0, 0, 1, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0, 0, 1);
    // Red held six cycles
    repeat (6) cycle(0, 0, 0, 0, 1, 1);
    repeat (3) cycle(0, 0, 0, 0, 0, 1);
    // Random level requests with occasional reds_on and reset
    rw = 0; rg = 0; rr = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) rw = ~rw;
      if ($urandom_range(0, 9) == 0) rg = ~rg;
      if ($urandom_range(0, 11) == 0) rr = ~rr;
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 49) == 0, rw, rg, rr, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
